// File: rtl/mtl_frame_prefetch.sv
// mtl_frame_prefetch
//
// Pixel source for the MTL LCD controller. Fetches one frame of 32-bit pixels
// (0x00RRGGBB) from SDRAM in bursts over an Avalon-MM style read master, holds
// them in a FIFO and hands back one pixel per read-enable with one cycle of
// latency. A new-frame pulse flushes the FIFO and restarts at the frame base.
//
// Ports:
//   iCLK, iRST_n          pixel clock, asynchronous active-low reset
//   iEnable               prefetch allowed (no new bursts while low)
//   iNewFrame             single-cycle pulse at x=0,y=0; restarts the frame
//   iPIX_RD               pixel read enable
//   oPIX_DATA             pixel, valid the cycle after iPIX_RD
//   oUNDERFLOW            sticky: a read found the FIFO empty
//   oMEM_READ/ADDR/BURSTCOUNT, iMEM_WAITREQUEST,
//   iMEM_READDATA/READDATAVALID   Avalon-MM burst read master
//   oMIN_LEVEL            lowest FIFO level seen since the last new frame,
//                         present only when MTL_PREFETCH_STATS_EN is defined
//
// Optional build macro: MTL_PREFETCH_STATS_EN (adds oMIN_LEVEL).
//
// FIFO_DEPTH must be a power of 2 and at least 2*BURST_LEN; BURST_LEN is 1..255.

module mtl_frame_prefetch #(
  parameter int unsigned       FIFO_DEPTH   = 512,
  parameter int unsigned       BURST_LEN    = 64,
  parameter int unsigned       FRAME_PIXELS = 384000,
  parameter int unsigned       ADDR_W       = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic                  iEnable,
  input  logic                  iNewFrame,
  input  logic                  iPIX_RD,
  output logic [31:0]           oPIX_DATA,
  output logic                  oUNDERFLOW,
  output logic                  oMEM_READ,
  output logic [ADDR_W-1:0]     oMEM_ADDR,
  output logic [7:0]            oMEM_BURSTCOUNT,
  input  logic                  iMEM_WAITREQUEST,
  input  logic [31:0]           iMEM_READDATA,
  input  logic                  iMEM_READDATAVALID
`ifdef MTL_PREFETCH_STATS_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0] oMIN_LEVEL
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned REM_W = $clog2(FRAME_PIXELS + 1);

  localparam logic [LVL_W-1:0] DepthLvl = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] BurstLvl = LVL_W'(BURST_LEN);
  localparam logic [REM_W-1:0] FrameRem = REM_W'(FRAME_PIXELS);
  localparam logic [7:0]       BurstCnt = 8'(BURST_LEN);

  typedef enum logic [1:0] {StIdle, StReq, StWaitData, StFlush} state_e;

  state_e state_q, state_d;

  // Frame walk: next burst address and words still to be requested this frame.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REM_W-1:0]  remaining_q, remaining_d;

  // Registered request towards the memory slave.
  logic              mem_read_q, mem_read_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_count_q, mem_count_d;

  // Beats still due from the outstanding burst (WAIT_DATA and FLUSH).
  logic [7:0] due_q, due_d;
  // A new frame arrived while the request was stalled; its data must be discarded.
  logic       nf_pend_q, nf_pend_d;

  // FIFO storage and pointers.
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic [31:0] pix_q, pix_d;
  logic        underflow_q, underflow_d;

  // Decoded per-cycle events.
  logic       accepted;
  logic       free_ok;
  logic       start_req;
  logic       beat;
  logic [7:0] due_after;
  logic [7:0] burst_cnt;
  logic       wr_en;
  logic       rd_hit;

  always_comb begin
    accepted  = (state_q == StReq) && mem_read_q && !iMEM_WAITREQUEST;
    free_ok   = (DepthLvl - level_q) >= BurstLvl;
    start_req = (state_q == StIdle) && !iNewFrame && iEnable &&
                (remaining_q != '0) && free_ok;
    beat      = iMEM_READDATAVALID && ((state_q == StWaitData) || (state_q == StFlush));
    due_after = due_q - {7'b0, beat};
    // Only beats of a live burst land in the FIFO; a new frame drops them.
    wr_en     = (state_q == StWaitData) && iMEM_READDATAVALID && !iNewFrame;
    rd_hit    = iPIX_RD && !iNewFrame && (level_q != '0);
    if (32'(remaining_q) < BURST_LEN) begin
      burst_cnt = 8'(remaining_q);
    end else begin
      burst_cnt = BurstCnt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d = StReq;
        end
      end
      StReq: begin
        // A stalled request cannot be withdrawn, so a new frame only changes
        // where its data goes once the slave takes it.
        if (accepted) begin
          state_d = (iNewFrame || nf_pend_q) ? StFlush : StWaitData;
        end
      end
      StWaitData: begin
        if (beat && (due_after == '0)) begin
          state_d = StIdle;
        end else if (iNewFrame) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (beat && (due_after == '0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: request, burst bookkeeping and frame-walk next values
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_read_d  = mem_read_q;
    mem_addr_d  = mem_addr_q;
    mem_count_d = mem_count_q;
    due_d       = due_q;
    nf_pend_d   = nf_pend_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          mem_read_d  = 1'b1;
          mem_addr_d  = addr_q;
          mem_count_d = burst_cnt;
          nf_pend_d   = 1'b0;
        end
      end
      StReq: begin
        if (accepted) begin
          mem_read_d = 1'b0;
          due_d      = mem_count_q;
          nf_pend_d  = 1'b0;
          // After a stalled new frame the walk already restarted at the base.
          if (!nf_pend_q) begin
            addr_d      = addr_q + ADDR_W'(mem_count_q);
            remaining_d = remaining_q - REM_W'(mem_count_q);
          end
        end else if (iNewFrame) begin
          nf_pend_d = 1'b1;
        end
      end
      StWaitData, StFlush: begin
        if (beat) begin
          due_d = due_after;
        end
      end
      default: ;
    endcase
    if (iNewFrame) begin
      addr_d      = BASE_ADDR;
      remaining_d = FrameRem;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (all registered)
  // ---------------------------------------------------------------------------
  always_comb begin
    oMEM_READ       = mem_read_q;
    oMEM_ADDR       = mem_addr_q;
    oMEM_BURSTCOUNT = mem_count_q;
    oPIX_DATA       = pix_q;
    oUNDERFLOW      = underflow_q;
  end

  // ---------------------------------------------------------------------------
  // FIFO and read side next values
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d    = rd_ptr_q + PTR_W'(rd_hit);
    level_d     = level_q + LVL_W'(wr_en) - LVL_W'(rd_hit);
    pix_d       = pix_q;
    underflow_d = underflow_q;
    if (iNewFrame) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      underflow_d = 1'b0;
      if (iPIX_RD) begin
        pix_d = '0;
      end
    end else if (iPIX_RD) begin
      if (level_q != '0) begin
        pix_d = fifo_mem[rd_ptr_q];
      end else begin
        // A same-cycle write is not yet readable, so this still underflows.
        pix_d       = '0;
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_q] <= iMEM_READDATA;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      addr_q      <= BASE_ADDR;
      remaining_q <= FrameRem;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_count_q <= '0;
      due_q       <= '0;
      nf_pend_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pix_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      mem_read_q  <= mem_read_d;
      mem_addr_q  <= mem_addr_d;
      mem_count_q <= mem_count_d;
      due_q       <= due_d;
      nf_pend_q   <= nf_pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pix_q       <= pix_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef MTL_PREFETCH_STATS_EN
  // Low-water mark of the FIFO, sampled on every read request.
  logic [LVL_W-1:0] min_level_q, min_level_d;

  always_comb begin
    min_level_d = min_level_q;
    if (iNewFrame) begin
      min_level_d = DepthLvl;
    end else if (iPIX_RD && (level_q < min_level_q)) begin
      min_level_d = level_q;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      min_level_q <= DepthLvl;
    end else begin
      min_level_q <= min_level_d;
    end
  end

  assign oMIN_LEVEL = min_level_q;
`endif

endmodule

// File: tb/tb_mtl_frame_prefetch.sv
module tb_mtl_frame_prefetch;

  localparam int unsigned FD = 16;
  localparam int unsigned BL = 4;
  localparam int unsigned FP = 10;
  localparam int unsigned AW = 24;
  localparam logic [23:0] BA = 24'h100;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        nf;
  logic        rd;
  logic [31:0] pix;
  logic        uf;
  logic        mread;
  logic [23:0] maddr;
  logic [7:0]  mcnt;
  logic        wreq;
  logic [31:0] rdata;
  logic        rvalid;
`ifdef MTL_PREFETCH_STATS_EN
  logic [4:0]  min_level;
`endif

  mtl_frame_prefetch #(
    .FIFO_DEPTH  (FD),
    .BURST_LEN   (BL),
    .FRAME_PIXELS(FP),
    .ADDR_W      (AW),
    .BASE_ADDR   (BA)
  ) dut (
    .iCLK              (clk),
    .iRST_n            (rst_n),
    .iEnable           (en),
    .iNewFrame         (nf),
    .iPIX_RD           (rd),
    .oPIX_DATA         (pix),
    .oUNDERFLOW        (uf),
    .oMEM_READ         (mread),
    .oMEM_ADDR         (maddr),
    .oMEM_BURSTCOUNT   (mcnt),
    .iMEM_WAITREQUEST  (wreq),
    .iMEM_READDATA     (rdata),
    .iMEM_READDATAVALID(rvalid)
`ifdef MTL_PREFETCH_STATS_EN
    ,
    .oMIN_LEVEL        (min_level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pixel queue plus the frame walk and the slave's burst state.
  logic [31:0] q[$];
  logic [31:0] exp_pix;
  logic        exp_uf;
  logic [23:0] mdl_addr;
  int          mdl_rem;
  logic        req_active;
  logic [23:0] req_addr;
  logic [7:0]  req_cnt;
  logic        req_disc;
  int          beats_left;
  int          beat_cnt;
  logic [23:0] beat_base;
  logic        beat_disc;
  logic [31:0] req_log[$];
  int          n_acc;
  int          n_stall;
  int          wait_hold;
  logic        rnd;

  typedef struct packed {
    logic        rd;
    logic        nf;
    logic [31:0] pix;
    logic        uf;
  } vec_t;
  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: snapshot pre-edge state, clock, update model, check, drive slave.
  task automatic cycle();
    logic        p_read;
    logic [23:0] p_addr;
    logic [7:0]  p_cnt;
    logic        c_nf, c_rd, c_wr, c_rv;
    logic [31:0] c_rdata;
    logic        acc;
    int          exp_cnt;
    p_read  = mread;
    p_addr  = maddr;
    p_cnt   = mcnt;
    c_nf    = nf;
    c_rd    = rd;
    c_wr    = wreq;
    c_rv    = rvalid;
    c_rdata = rdata;
    @(posedge clk);
    @(negedge clk);
    if (p_read && !req_active) begin
      exp_cnt = (mdl_rem < int'(BL)) ? mdl_rem : int'(BL);
      check("req_addr", 32'(p_addr), 32'(mdl_addr));
      check("req_cnt", 32'(p_cnt), 32'(exp_cnt));
      req_active = 1'b1;
      req_addr   = p_addr;
      req_cnt    = p_cnt;
      req_disc   = 1'b0;
      req_log.push_back({p_addr, p_cnt});
      mdl_addr   = mdl_addr + 24'(p_cnt);
      mdl_rem    = mdl_rem - int'(p_cnt);
    end else if (req_active) begin
      check("req_held", 32'(p_read), 32'd1);
      check("req_addr_stable", 32'(p_addr), 32'(req_addr));
      check("req_cnt_stable", 32'(p_cnt), 32'(req_cnt));
    end
    if (p_read && c_wr) n_stall++;
    acc = p_read && !c_wr;
    if (c_nf) begin
      if (req_active) req_disc = 1'b1;
      if (beats_left > 0) beat_disc = 1'b1;
      q.delete();
      if (c_rd) exp_pix = '0;
      exp_uf   = 1'b0;
      mdl_addr = BA;
      mdl_rem  = int'(FP);
    end else if (c_rd) begin
      if (q.size() > 0) begin
        exp_pix = q.pop_front();
      end else begin
        exp_pix = '0;
        exp_uf  = 1'b1;
      end
    end
    if (c_rv) begin
      if (!beat_disc && !c_nf) q.push_back(c_rdata);
      beats_left--;
    end
    if (acc) begin
      n_acc++;
      req_active = 1'b0;
      beats_left = int'(req_cnt);
      beat_cnt   = int'(req_cnt);
      beat_base  = req_addr;
      beat_disc  = req_disc;
    end
    check("pix_data", pix, exp_pix);
    check("underflow", 32'(uf), 32'(exp_uf));
    // Slave response for the next cycle.
    if (wait_hold > 0 && mread) begin
      wreq = 1'b1;
      wait_hold--;
    end else begin
      wreq = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    if (beats_left > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
      rvalid = 1'b1;
      rdata  = 32'(beat_base) + 32'(beat_cnt - beats_left);
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
  endtask

  task automatic do_reset(input logic enable);
    @(negedge clk);
    rst_n  = 1'b0;
    en     = enable;
    nf     = 1'b0;
    rd     = 1'b0;
    wreq   = 1'b0;
    rvalid = 1'b0;
    rdata  = '0;
    #1;
    check("rst_pix", pix, 32'd0);
    check("rst_uf", 32'(uf), 32'd0);
    check("rst_read", 32'(mread), 32'd0);
    check("rst_addr", 32'(maddr), 32'(BA));
    check("rst_cnt", 32'(mcnt), 32'd0);
    repeat (2) @(negedge clk);
    q.delete();
    req_log.delete();
    exp_pix    = '0;
    exp_uf     = 1'b0;
    mdl_addr   = BA;
    mdl_rem    = int'(FP);
    req_active = 1'b0;
    req_disc   = 1'b0;
    beats_left = 0;
    beat_cnt   = 0;
    beat_disc  = 1'b0;
    n_acc      = 0;
    n_stall    = 0;
    wait_hold  = 0;
    rst_n      = 1'b1;
  endtask

  logic [31:0] exp_req[3];
  logic [31:0] got;
  int          seen;

  initial begin
    // Read-out table after a full frame has been fetched.
    for (int i = 0; i < 15; i++) tbl[i] = '{rd: 1'b1, nf: 1'b0, pix: 32'd0, uf: 1'b0};
    for (int i = 0; i < 3; i++) tbl[i].pix = 32'h100 + 32'(i);
    tbl[3] = '{rd: 1'b0, nf: 1'b0, pix: 32'h102, uf: 1'b0};
    for (int i = 4; i < 11; i++) tbl[i].pix = 32'h100 + 32'(i - 1);
    tbl[11] = '{rd: 1'b1, nf: 1'b0, pix: 32'd0, uf: 1'b1};
    tbl[12] = '{rd: 1'b0, nf: 1'b0, pix: 32'd0, uf: 1'b1};
    tbl[13] = '{rd: 1'b0, nf: 1'b1, pix: 32'd0, uf: 1'b0};
    tbl[14] = '{rd: 1'b0, nf: 1'b0, pix: 32'd0, uf: 1'b0};
    exp_req[0] = {24'h100, 8'd4};
    exp_req[1] = {24'h104, 8'd4};
    exp_req[2] = {24'h108, 8'd2};

    rnd   = 1'b0;
    rst_n = 1'b1;
    en = 1'b0; nf = 1'b0; rd = 1'b0; wreq = 1'b0; rvalid = 1'b0; rdata = '0;

    // Full frame fetch: three bursts, then nothing more.
    do_reset(1'b1);
    repeat (40) cycle();
    check("req_count", 32'(req_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      got = (i < req_log.size()) ? req_log[i] : 32'hFFFF_FFFF;
      check("req_seq", got, exp_req[i]);
    end
    en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      rd = tbl[i].rd;
      nf = tbl[i].nf;
      cycle();
      check("tbl_pix", pix, tbl[i].pix);
      check("tbl_uf", 32'(uf), 32'(tbl[i].uf));
    end
    rd = 1'b0;
    nf = 1'b0;

    // Five stalled cycles on the first request.
    do_reset(1'b1);
    wait_hold = 5;
    repeat (40) cycle();
    check("stall_cycles", 32'(n_stall), 32'd5);
    check("accept_count", 32'(n_acc), 32'd3);
    got = (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF;
    check("stall_req0", got, exp_req[0]);

    // New frame two beats into the first burst.
    do_reset(1'b1);
    for (int i = 0; i < 50 && !(beats_left == 2 && beat_cnt == 4); i++) cycle();
    check("nf_sync", 32'(beats_left), 32'd2);
    req_log.delete();
    nf = 1'b1;
    cycle();
    nf = 1'b0;
    repeat (40) cycle();
    got = (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF;
    check("nf_req0", got, exp_req[0]);
    rd = 1'b1;
    cycle();
    rd = 1'b0;
    check("nf_first_pix", pix, 32'h100);

    // Disabled from reset, then enabled.
    do_reset(1'b0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (mread) seen++;
    end
    check("no_req_disabled", 32'(seen), 32'd0);
    en = 1'b1;
    cycle();
    check("req_on_enable", 32'(mread), 32'd1);
    check("req_on_enable_addr", 32'(maddr), 32'h100);

    // Randomized traffic against the reference model.
    rnd = 1'b1;
    do_reset(1'b1);
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset(1'b1);
      en = ($urandom_range(0, 9) != 0);
      rd = ($urandom_range(0, 2) == 0);
      nf = ($urandom_range(0, 29) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
